// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (MAGIC, LEN[4] little-endian,
// payload, CSUM) and writes the payload into program memory at ascending byte
// addresses. Holds the core in reset while loading and reports done/error.
module program_loader #(
    parameter int unsigned MEM_BYTES      = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        write_enable,
    output logic [7:0]  write_data,
    output logic [31:0] write_address,
    output logic        clear_mem,
    output logic        cpu_reset,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   len_q, len_d;
    logic [1:0]    len_idx_q, len_idx_d;
    logic [31:0]   offset_q, offset_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [31:0]   waddr_q, waddr_d;
    logic          clr_q, clr_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          expired;
    logic          fail;

    // Idle-cycle counter has hit its limit; a byte arriving this cycle still wins.
    assign expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic for the frame parser.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        len_idx_d = len_idx_q;
        offset_d  = offset_q;
        csum_d    = csum_q;
        tmo_d     = tmo_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        clr_d     = 1'b0;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        fail      = 1'b0;

        if (state_q == StLen || state_q == StData || state_q == StCheck) begin
            tmo_d = rx_valid ? '0 : tmo_q + TW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == MAGIC) begin
                    clr_d     = 1'b1;
                    cpu_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    len_d     = '0;
                    len_idx_d = '0;
                    offset_d  = '0;
                    csum_d    = '0;
                    tmo_d     = '0;
                    state_d   = StLen;
                end
            end
            StLen: begin
                if (rx_valid) begin
                    // Shift in from the top so the first (LSB) byte ends at [7:0].
                    len_d     = {rx_data, len_q[31:8]};
                    len_idx_d = len_idx_q + 2'd1;
                    if (len_idx_q == 2'd3) begin
                        if (len_d > MEM_BYTES) begin
                            fail = 1'b1;
                        end else if (len_d == 32'd0) begin
                            state_d = StCheck;
                        end else begin
                            state_d = StData;
                        end
                    end
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            StData: begin
                if (rx_valid) begin
                    we_d     = 1'b1;
                    wdata_d  = rx_data;
                    waddr_d  = BASE_ADDR + offset_q;
                    offset_d = offset_q + 32'd1;
                    csum_d   = csum_q + rx_data;
                    if (offset_d == len_q) begin
                        state_d = StCheck;
                    end
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            StCheck: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = StDone;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Core stays held in reset after a failed load.
        if (fail) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = StError;
        end
    end

    // State and output registers; memory contents are never touched by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            len_q     <= '0;
            len_idx_q <= '0;
            offset_q  <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            waddr_q   <= BASE_ADDR;
            clr_q     <= 1'b0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            len_idx_q <= len_idx_d;
            offset_q  <= offset_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
            clr_q     <= clr_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign write_enable  = we_q;
    assign write_data    = wdata_q;
    assign write_address = waddr_q;
    assign clear_mem     = clr_q;
    assign cpu_reset     = cpu_rst_q;
    assign busy          = busy_q;
    assign load_done     = done_q;
    assign load_error    = err_q;

endmodule
